// File: rtl/security_access_ctrl_if.sv
// Keypad and status bundle for security_access_ctrl.
// master drives keys and code loads and observes status; slave is the controller.
interface security_access_ctrl_if;
  logic       key_valid;
  logic [1:0] key;
  logic       clear;
  logic       code_load;
  logic [5:0] code_in;
  logic       lock;
  logic       lockout;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;

  modport master (
    output key_valid, key, clear, code_load, code_in,
    input  lock, lockout, fail_cnt, state_o
  );

  modport slave (
    input  key_valid, key, clear, code_load, code_in,
    output lock, lockout, fail_cnt, state_o
  );
endinterface

// File: rtl/security_access_ctrl.sv
// Three-digit keypad lock with auto-relock timer and entry timeout.
// Define SECURITY_LOCKOUT_EN to enter a timed LOCKOUT after MAX_FAIL failed attempts.
module security_access_ctrl #(
  parameter int UNLOCK_CYCLES  = 16,
  parameter int ENTRY_TIMEOUT  = 32,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int MAX_FAIL       = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  security_access_ctrl_if.slave bus
);
  // state   | meaning
  // IDLE    | locked, waiting for first digit
  // D1      | first digit accepted, waiting for second
  // D2      | second digit accepted, waiting for third
  // OPEN    | unlocked until timer expiry or clear
  // LOCKOUT | too many failures, all inputs ignored
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D1      = 3'd1,
    D2      = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [5:0] code, code_nxt;
  logic [1:0] fail_q, fail_nxt, fail_inc;
  logic       lock_q, lock_nxt;
  logic [1:0] digit;
  logic       digit_ok;
  logic       lockout_en;
  logic       enter_lockout;

  always_comb begin
    case (state)
      D1:      digit = code[3:2];
      D2:      digit = code[1:0];
      default: digit = code[5:4];
    endcase
  end

  // key 0 never matches, even if a loaded code contains a zero digit
  assign digit_ok      = (bus.key == digit) && (bus.key != 2'd0);
  assign fail_inc      = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
  assign enter_lockout = lockout_en && (int'(fail_inc) >= MAX_FAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= 8'd0;
      code   <= 6'b11_01_10;
      fail_q <= 2'd0;
      lock_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      code   <= code_nxt;
      fail_q <= fail_nxt;
      lock_q <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    code_nxt  = code;
    fail_nxt  = fail_q;
    case (state)
      IDLE, D1, D2: begin
        if (bus.clear) begin
          state_nxt = IDLE;
          timer_nxt = 8'd0;
        end else if (bus.key_valid) begin
          if (!digit_ok) begin
            fail_nxt = fail_inc;
            if (enter_lockout) begin
              state_nxt = LOCKOUT;
              timer_nxt = 8'(LOCKOUT_CYCLES);
            end else begin
              state_nxt = IDLE;
              timer_nxt = 8'd0;
            end
          end else if (state == D2) begin
            state_nxt = OPEN;
            fail_nxt  = 2'd0;
            timer_nxt = 8'(UNLOCK_CYCLES);
          end else begin
            state_nxt = (state == IDLE) ? D1 : D2;
            timer_nxt = 8'(ENTRY_TIMEOUT);
          end
        end else if (state != IDLE) begin
          if (timer == 8'd0) state_nxt = IDLE;
          else               timer_nxt = timer - 8'd1;
        end
      end
      OPEN: begin
        if (bus.code_load) code_nxt = bus.code_in;
        if (bus.clear || timer == 8'd0) begin
          state_nxt = IDLE;
          timer_nxt = 8'd0;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      LOCKOUT: begin
        if (timer == 8'd0) begin
          state_nxt = IDLE;
          fail_nxt  = 2'd0;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = 8'd0;
      end
    endcase
  end

  always_comb begin
    lock_nxt = (state_nxt != OPEN);
  end

  assign bus.lock     = lock_q;
  assign bus.fail_cnt = fail_q;
  assign bus.state_o  = state;

`ifdef SECURITY_LOCKOUT_EN
  logic lockout_q;

  assign lockout_en = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lockout_q <= 1'b0;
    else        lockout_q <= (state_nxt == LOCKOUT);
  end

  assign bus.lockout = lockout_q;
`else
  assign lockout_en  = 1'b0;
  assign bus.lockout = 1'b0;
`endif
endmodule

// File: tb/tb_security_access_ctrl.sv
// Randomized bench for security_access_ctrl against a phase/deadline model.
// Build with SECURITY_LOCKOUT_EN defined to exercise the lockout variant.
module tb_security_access_ctrl;
  localparam int UNLOCK_CYCLES  = 16;
  localparam int ENTRY_TIMEOUT  = 32;
  localparam int LOCKOUT_CYCLES = 64;
  localparam int MAX_FAIL       = 3;
`ifdef SECURITY_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  security_access_ctrl_if bus ();

  security_access_ctrl #(
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .ENTRY_TIMEOUT (ENTRY_TIMEOUT),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .MAX_FAIL      (MAX_FAIL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // model: phase 0 idle, 1/2 digits accepted, 3 open, 4 locked out;
  // deadline is the absolute edge index at which a timed phase ends
  int         ph       = 0;
  int         fails    = 0;
  int         deadline = 0;
  int         cyc      = 0;
  logic [5:0] mcode    = 6'b11_01_10;

  function automatic int exp_digit(input int p);
    int c;
    c = int'(mcode);
    return (c >> (4 - 2 * p)) & 3;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; fails = 0; deadline = 0; cyc = 0; mcode = 6'b11_01_10;
    end else begin
      cyc++;
      if (ph == 4) begin
        if (cyc >= deadline) begin ph = 0; fails = 0; end
      end else if (bus.clear) begin
        if (ph == 3 && bus.code_load) mcode = bus.code_in;
        ph = 0;
      end else if (ph == 3) begin
        if (bus.code_load) mcode = bus.code_in;
        if (cyc >= deadline) ph = 0;
      end else if (bus.key_valid) begin
        if (bus.key != 2'd0 && int'(bus.key) == exp_digit(ph)) begin
          if (ph == 2) begin
            ph = 3; fails = 0; deadline = cyc + UNLOCK_CYCLES + 1;
          end else begin
            ph++; deadline = cyc + ENTRY_TIMEOUT + 1;
          end
        end else begin
          fails = (fails < 3) ? fails + 1 : 3;
          if (LOCK_EN && fails >= MAX_FAIL) begin
            ph = 4; deadline = cyc + LOCKOUT_CYCLES + 1;
          end else begin
            ph = 0;
          end
        end
      end else if (ph != 0 && cyc >= deadline) begin
        ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state_o",  int'(bus.state_o),  ph);
      check("lock",     int'(bus.lock),     int'(ph != 3));
      check("lockout",  int'(bus.lockout),  int'(ph == 4));
      check("fail_cnt", int'(bus.fail_cnt), fails);
    end
  end

  task automatic step(input bit kv, input logic [1:0] k, input bit clr,
                      input bit ld, input logic [5:0] ci);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key       = k;
    bus.clear     = clr;
    bus.code_load = ld;
    bus.code_in   = ci;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 6'd0);
  endtask

  // reset asserted between edges so the asynchronous path is exercised
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.key_valid = 1'b0; bus.key = 2'd0; bus.clear = 1'b0;
    bus.code_load = 1'b0; bus.code_in = 6'd0;
    #1;
    check("rst_state",   int'(bus.state_o),  0);
    check("rst_lock",    int'(bus.lock),     1);
    check("rst_lockout", int'(bus.lockout),  0);
    check("rst_fail",    int'(bus.fail_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic enter_code(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    step(1'b1, a, 1'b0, 1'b0, 6'd0);
    step(1'b1, b, 1'b0, 1'b0, 6'd0);
    step(1'b1, c, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         kv, clr, ld;
    logic [1:0] k;
    logic [5:0] ci;

    bus.key_valid = 1'b0; bus.key = 2'd0; bus.clear = 1'b0;
    bus.code_load = 1'b0; bus.code_in = 6'd0;
    do_reset();
    chk_en = 1'b1;

    // default code opens, then relocks UNLOCK_CYCLES+1 edges later
    enter_code(2'd3, 2'd1, 2'd2);
    idle(1);
    check("open_after_code", int'(bus.lock), 0);
    idle(UNLOCK_CYCLES);
    check("still_open", int'(bus.lock), 0);
    idle(1);
    check("relocked", int'(bus.lock), 1);

    do_reset();
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 6'd0);
    idle(1);
    check("wrong2_fail", int'(bus.fail_cnt), 1);
    check("wrong2_state", int'(bus.state_o), 0);
    check("wrong2_lock", int'(bus.lock), 1);

    do_reset();
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0);
    idle(1);
    check("d1_entered", int'(bus.state_o), 1);
    idle(ENTRY_TIMEOUT);
    check("d1_last_cycle", int'(bus.state_o), 1);
    idle(1);
    check("timeout_state", int'(bus.state_o), 0);
    check("timeout_nofail", int'(bus.fail_cnt), 0);

    do_reset();
    enter_code(2'd3, 2'd1, 2'd2);
    idle(1);
    step(1'b0, 2'd0, 1'b0, 1'b1, 6'b01_10_11);
    step(1'b0, 2'd0, 1'b1, 1'b0, 6'd0);
    enter_code(2'd1, 2'd2, 2'd3);
    idle(1);
    check("new_code_open", int'(bus.lock), 0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 6'd0);
    enter_code(2'd3, 2'd1, 2'd2);
    idle(1);
    check("old_code_lock", int'(bus.lock), 1);
    check("old_code_fail", int'(bus.fail_cnt), 1);

    do_reset();
    step(1'b1, 2'd2, 1'b0, 1'b0, 6'd0);
    step(1'b1, 2'd3, 1'b1, 1'b0, 6'd0);
    idle(1);
    check("clear_wins_state", int'(bus.state_o), 0);
    check("clear_wins_fail", int'(bus.fail_cnt), 1);
    enter_code(2'd3, 2'd1, 2'd2);
    idle(1);
    check("open_before_rst", int'(bus.lock), 0);
    do_reset();

    step(1'b1, 2'd0, 1'b0, 1'b0, 6'd0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 6'd0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 6'd0);
    idle(1);
`ifdef SECURITY_LOCKOUT_EN
    check("lockout_set", int'(bus.lockout), 1);
    check("lockout_state", int'(bus.state_o), 4);
    enter_code(2'd3, 2'd1, 2'd2);
    check("lockout_keys_ignored", int'(bus.lock), 1);
    idle(LOCKOUT_CYCLES - 3);
    check("lockout_last_cycle", int'(bus.state_o), 4);
    idle(1);
    check("lockout_exit_state", int'(bus.state_o), 0);
    check("lockout_exit_fail", int'(bus.fail_cnt), 0);
    check("lockout_exit_flag", int'(bus.lockout), 0);
`else
    check("sat_fail", int'(bus.fail_cnt), 3);
    check("no_lockout", int'(bus.lockout), 0);
    check("no_lockout_state", int'(bus.state_o), 0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 6'd0);
    idle(1);
    check("sat_hold", int'(bus.fail_cnt), 3);
`endif

    do_reset();
    for (int n = 0; n < 4000; n++) begin
      kv  = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 70) k = 2'(exp_digit((ph < 3) ? ph : 0));
      else                            k = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 99) < 4);
      ld  = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 3) == 0) ci = 6'($urandom_range(0, 63));
      else ci = {2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3))};
      if ($urandom_range(0, 999) < 3) do_reset();
      else if ($urandom_range(0, 99) < 5) idle($urandom_range(20, 70));
      step(kv, k, clr, ld, ci);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
